// File: rtl/mem_pkg.sv
// Shared defaults and response record for the main-memory responder and its latency pipe.
package mem_pkg;

   localparam int MEM_ADDR_W      = 16;
   localparam int MEM_DATA_W      = 16;
   localparam int MEM_LATENCY     = 4;
   localparam int MEM_DEPTH_WORDS = 2 ** (MEM_ADDR_W - 1);

   typedef struct packed {
      logic                  valid;
      logic [MEM_DATA_W-1:0] data;
   } mem_rsp_t;

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth {valid, data} shift pipeline with synchronous flush; the last stage only
// loads on a valid entry so its data holds the most recent response.
module mem_latency_pipe #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DATA_W:0] rsp_i,
   output logic [DATA_W:0] rsp_o,
   output logic            busy_o
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } rsp_t;

   rsp_t stage_q [DEPTH];
   rsp_t stage_d [DEPTH];

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         stage_d[i] = (i == 0) ? rsp_t'(rsp_i) : stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i].valid <= stage_d[i].valid;
            if ((i != DEPTH - 1) || stage_d[i].valid) begin
               stage_q[i].data <= stage_d[i].data;
            end
         end
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         busy_o = busy_o | stage_q[i].valid;
      end
   end

   assign rsp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/main_memory_responder.sv
// Off-chip DRAM model: one word request per cycle, reads return LATENCY cycles later in order.
// Optional MEM_ERR_CHECK_EN flags odd-address requests on err, drops such writes and zeroes such reads.
module main_memory_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int LATENCY     = MEM_LATENCY,
   parameter int DEPTH_WORDS = MEM_DEPTH_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0]  word_idx;
   logic              odd_addr;
   logic              wr_en;
   logic              rd_en;
   mem_rsp_t          req_rsp;
   mem_rsp_t          out_rsp;

   // Truncating to IDX_W bits gives the modulo-DEPTH_WORDS wrap for free.
   assign word_idx = addr[IDX_W:1];

`ifdef MEM_ERR_CHECK_EN
   logic err_q;

   assign odd_addr = addr[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= enable & addr[0];
      end
   end

   assign err = err_q;
`else
   logic unused_addr_lsb;

   assign unused_addr_lsb = addr[0];
   assign odd_addr        = 1'b0;
   assign err             = 1'b0;
`endif

   assign wr_en = enable & wr & ~rst & ~odd_addr;
   assign rd_en = enable & ~wr & ~rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[word_idx] <= data_in;
      end
   end

   // Storage is sampled at the issue edge, so a later write to the same word cannot reach an in-flight read.
   always_comb begin
      req_rsp       = '0;
      req_rsp.valid = rd_en;
      req_rsp.data  = odd_addr ? '0 : mem_q[word_idx];
   end

   mem_latency_pipe #(
      .DEPTH  (LATENCY),
      .DATA_W (DATA_W)
   ) u_pipe (
      .clk    (clk),
      .rst    (rst),
      .rsp_i  (req_rsp),
      .rsp_o  (out_rsp),
      .busy_o (busy)
   );

   assign data_valid = out_rsp.valid;
   assign data_out   = out_rsp.data;

endmodule
